iopad_bidir_ctrl: RTL and testbench
===================================

# iopad_bidir_ctrl

Core-side controller for one C4M Sky130 bidirectional IO pad, sitting between core logic and the pad cell's `c2p` / `c2p_en` / `p2c` pins. It turns a core "drive" request into a glitch-free output-enable sequence with bus-turnaround dead cycles. It also synchronizes and deglitches the pad input into a clean level with edge pulses. One instance per bidir pad in the IO ring wrapper.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `p2c` synchronizer chain; legal range 2..4.
- `FILT_CYCLES`, 4: consecutive stable synchronized cycles required before `in_q` changes; legal range 1..255.
- `TURN_CYCLES`, 2: dead cycles with `c2p_en`=0 on every direction change; legal range 1..15.

Ports:
- `ck` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `out_req` in 1: core requests to drive the pad; level-sensitive.
- `out_d` in 1: data to drive; sampled every cycle.
- `drive` out 1: high while in TX, meaning the pad is being driven.
- `busy` out 1: high in either turnaround state.
- `in_q` out 1: filtered, synchronized pad level.
- `in_rise` out 1: one-cycle pulse when `in_q` goes 0→1.
- `in_fall` out 1: one-cycle pulse when `in_q` goes 1→0.
- `c2p` out 1: to pad, output data.
- `c2p_en` out 1: to pad, output enable.
- `p2c` in 1: from pad, asynchronous input level.

## Operation
- All outputs are registered. Reset values:
  - `c2p`=0, `c2p_en`=0, `drive`=0, `busy`=0
  - `in_q`=0, `in_rise`=0, `in_fall`=0
  - state RX, sync chain all 0, filter counter 0
- Direction FSM:
  - **RX**: `c2p_en`=0. If `out_req`=1, go to TO_TX and load turn counter with TURN_CYCLES-1.
  - **TO_TX**: `c2p_en`=0, `busy`=1.
    - If `out_req`=0, go to RX next cycle (abort, pad never driven).
    - Otherwise, when the counter reaches 0, go to TX; else decrement.
  - **TX**: `c2p_en`=1, `drive`=1, `c2p`=`out_d` registered each cycle. If `out_req`=0, go to TO_RX and load the counter.
  - **TO_RX**: `c2p_en`=0, `busy`=1, `c2p` forced to 0. `out_req` is ignored. When the counter reaches 0, go to RX.
- Invariant: `c2p_en` never goes 0→1 or 1→0 without at least TURN_CYCLES cycles of `c2p_en`=0 on each side of a TX interval.
- Input path:
  - `p2c` passes through SYNC_STAGES flops, giving `s`.
  - Filter counter: reset to 0 whenever `s`==`in_q`; increment while `s`≠`in_q`.
  - When the counter equals FILT_CYCLES-1 and `s`≠`in_q`, set `in_q` to `s`, clear the counter, and pulse `in_rise` or `in_fall` for one cycle.
- The input path runs in every state, including TX (pad loopback is visible).
- The counter width is the minimum bits for FILT_CYCLES; it must never wrap.
- `rst` mid-operation (any state): the next cycle shows the reset values. `c2p_en` drops immediately; this is the only permitted exception to the turnaround rule.

## Timing
- `out_req` rising at edge t in RX:
  - `busy`=1 at t+1.
  - `c2p_en`=1 and `drive`=1 at t+1+TURN_CYCLES.
- `out_req` falling at edge t in TX:
  - `c2p_en`=0 at t+1.
  - RX, with `busy`=0, at t+1+TURN_CYCLES.
  - Earliest re-drive is at t+1+TURN_CYCLES+1+TURN_CYCLES.
- `out_d` to `c2p` latency: 1 cycle while in TX.
- `p2c` stable new level from edge t: `in_q` and the pulse appear at t+SYNC_STAGES+FILT_CYCLES.
- A `p2c` glitch shorter than FILT_CYCLES cycles (post-sync) produces no `in_q` change and no pulse.
- `in_rise` and `in_fall` are never high together.

## Structure
- Package `iopad_pkg`: state enum `{RX, TO_TX, TX, TO_RX}` and parameter range constants.
- Sub-module `iopad_sync_filter`: contains the synchronizer chain, filter counter, `in_q` and the edge pulses. Parameters: SYNC_STAGES, FILT_CYCLES.
- The direction FSM stays in the top module.

## Test plan
- Reset: hold `rst` 3 cycles with `out_req`=1 and `p2c`=1 → all outputs 0 during reset; `c2p_en` first rises 1+TURN_CYCLES cycles after `rst` falls.
- Drive cycle (TURN=2): `out_req`=1 at t, `out_d` toggling → `c2p_en`=1 from t+3 and `c2p` follows `out_d` with 1-cycle lag; `out_req`=0 at t+10 → `c2p_en`=0 at t+11 and `busy`=0 at t+13.
- Abort: `out_req` pulsed high for 1 cycle → `busy` high for 1 cycle, `c2p_en` stays 0 throughout.
- Re-request during TO_RX: `out_req` 1→0→1 on consecutive cycles in TX → TO_RX runs its full TURN_CYCLES, then TO_TX; `c2p_en` shows a gap of at least 2×TURN_CYCLES+1 cycles.
- Filter (FILT=4, SYNC=2):
  - `p2c`=1 for 3 cycles, then 0 → no `in_rise`.
  - `p2c`=1 held from t → `in_q`=1 and `in_rise` single pulse at t+6.
  - `p2c`=0 held → `in_fall` pulse 6 cycles later.
- Reset mid-TX: assert `rst` while `c2p_en`=1 → `c2p_en`=0 the next cycle, state RX, `in_q` cleared.

Source files
------------

// File: rtl/iopad_pkg.sv
// iopad_pkg: shared direction-FSM states, parameter limits and counter sizing for the bidir pad controller
package iopad_pkg;
    typedef enum logic [1:0] {RX, TO_TX, TX, TO_RX} dir_state_t;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;
    localparam int FILT_MIN = 1;
    localparam int FILT_MAX = 255;
    localparam int TURN_MIN = 1;
    localparam int TURN_MAX = 15;
    localparam int TURN_W = $clog2(TURN_MAX + 1);
    function automatic int cnt_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/iopad_sync_filter.sv
// iopad_sync_filter: synchronizes the async pad input and deglitches it into a clean level with edge pulses
module iopad_sync_filter
    import iopad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic ck,
    input  logic rst,
    input  logic p2c,
    output logic in_q,
    output logic in_rise,
    output logic in_fall
);
    localparam int CW = cnt_width(FILT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);
    logic [SYNC_STAGES-1:0] chain;
    logic [CW-1:0] cnt;
    logic s;
    assign s = chain[SYNC_STAGES-1];
    always_ff @(posedge ck) begin
        if (rst) begin
            chain <= '0;
            cnt <= '0;
            in_q <= 1'b0;
            in_rise <= 1'b0;
            in_fall <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], p2c};
            in_rise <= 1'b0;
            in_fall <= 1'b0;
            if (s == in_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // counter clears on acceptance, so it never reaches a value that could wrap
                in_q <= s;
                cnt <= '0;
                in_rise <= s;
                in_fall <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/iopad_bidir_ctrl.sv
// iopad_bidir_ctrl: core-side bidir pad controller with turnaround dead cycles and a filtered input path
module iopad_bidir_ctrl
    import iopad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int TURN_CYCLES = 2
) (
    input  logic ck,
    input  logic rst,
    input  logic out_req,
    input  logic out_d,
    output logic drive,
    output logic busy,
    output logic in_q,
    output logic in_rise,
    output logic in_fall,
    output logic c2p,
    output logic c2p_en,
    input  logic p2c
);
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("SYNC_STAGES out of range");
    end
    if (FILT_CYCLES < FILT_MIN || FILT_CYCLES > FILT_MAX) begin : g_bad_filt
        $error("FILT_CYCLES out of range");
    end
    if (TURN_CYCLES < TURN_MIN || TURN_CYCLES > TURN_MAX) begin : g_bad_turn
        $error("TURN_CYCLES out of range");
    end
    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYCLES - 1);
    dir_state_t st, nxt;
    logic [TURN_W-1:0] cnt, cnt_nxt;
    always_comb begin
        nxt = st;
        cnt_nxt = cnt;
        case (st)
            RX: begin
                if (out_req) begin
                    nxt = TO_TX;
                    cnt_nxt = TURN_LOAD;
                end
            end
            TO_TX: begin
                if (!out_req) nxt = RX;
                else if (cnt == '0) nxt = TX;
                else cnt_nxt = cnt - 1'b1;
            end
            TX: begin
                if (!out_req) begin
                    nxt = TO_RX;
                    cnt_nxt = TURN_LOAD;
                end
            end
            TO_RX: begin
                if (cnt == '0) nxt = RX;
                else cnt_nxt = cnt - 1'b1;
            end
            default: nxt = RX;
        endcase
    end
    // outputs decode the next state so every pad-facing pin comes straight from a flop
    always_ff @(posedge ck) begin
        if (rst) begin
            st <= RX;
            cnt <= '0;
            c2p <= 1'b0;
            c2p_en <= 1'b0;
            drive <= 1'b0;
            busy <= 1'b0;
        end else begin
            st <= nxt;
            cnt <= cnt_nxt;
            c2p <= (nxt == TX) && out_d;
            c2p_en <= nxt == TX;
            drive <= nxt == TX;
            busy <= (nxt == TO_TX) || (nxt == TO_RX);
        end
    end
    iopad_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES)
    ) u_filter (
        .ck(ck),
        .rst(rst),
        .p2c(p2c),
        .in_q(in_q),
        .in_rise(in_rise),
        .in_fall(in_fall)
    );
endmodule

// File: tb/tb_iopad_bidir_ctrl.sv
// tb_iopad_bidir_ctrl: directed vectors for the bidir pad controller (SYNC=2, FILT=4, TURN=2)
module tb_iopad_bidir_ctrl;
    logic ck = 1'b0;
    logic rst, out_req, out_d, p2c;
    logic drive, busy, in_q, in_rise, in_fall, c2p, c2p_en;
    int checks = 0;
    int errors = 0;
    always #5 ck = ~ck;
    iopad_bidir_ctrl #(
        .SYNC_STAGES(2),
        .FILT_CYCLES(4),
        .TURN_CYCLES(2)
    ) dut (
        .ck(ck),
        .rst(rst),
        .out_req(out_req),
        .out_d(out_d),
        .drive(drive),
        .busy(busy),
        .in_q(in_q),
        .in_rise(in_rise),
        .in_fall(in_fall),
        .c2p(c2p),
        .c2p_en(c2p_en),
        .p2c(p2c)
    );
    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge ck);
        #1;
    endtask
    initial begin
        rst = 1'b1;
        out_req = 1'b1;
        out_d = 1'b0;
        p2c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_c2p_en%0d", i), c2p_en, 1'b0);
            check($sformatf("rst_busy%0d", i), busy, 1'b0);
            check($sformatf("rst_drive%0d", i), drive, 1'b0);
            check($sformatf("rst_in_q%0d", i), in_q, 1'b0);
            check($sformatf("rst_c2p%0d", i), c2p, 1'b0);
        end
        rst = 1'b0;
        // request and pad-high both start at the first edge out of reset
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("up_busy%0d", i), busy, i <= 2);
            check($sformatf("up_c2p_en%0d", i), c2p_en, i >= 3);
            check($sformatf("up_drive%0d", i), drive, i >= 3);
            check($sformatf("up_in_q%0d", i), in_q, i >= 6);
            check($sformatf("up_in_rise%0d", i), in_rise, i == 6);
            check($sformatf("up_in_fall%0d", i), in_fall, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            out_d = (i % 3) != 0;
            tick();
            check($sformatf("tx_c2p%0d", i), c2p, (i % 3) != 0);
            check($sformatf("tx_c2p_en%0d", i), c2p_en, 1'b1);
        end
        out_req = 1'b0;
        out_d = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("dn_c2p_en%0d", i), c2p_en, 1'b0);
            check($sformatf("dn_c2p%0d", i), c2p, 1'b0);
            check($sformatf("dn_busy%0d", i), busy, i <= 2);
        end
        p2c = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("fall_in_q%0d", i), in_q, i < 6);
            check($sformatf("fall_pulse%0d", i), in_fall, i == 6);
            check($sformatf("fall_rise%0d", i), in_rise, 1'b0);
        end
        out_req = 1'b1;
        tick();
        check("abort_busy1", busy, 1'b1);
        check("abort_c2p_en1", c2p_en, 1'b0);
        out_req = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("abort_busy%0d", i), busy, 1'b0);
            check($sformatf("abort_c2p_en%0d", i), c2p_en, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            p2c = i < 3;
            tick();
            check($sformatf("glitch_in_q%0d", i), in_q, 1'b0);
            check($sformatf("glitch_rise%0d", i), in_rise, 1'b0);
        end
        out_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("rr_up_c2p_en%0d", i), c2p_en, i >= 3);
        end
        out_req = 1'b0;
        tick();
        check("rr_drop_c2p_en", c2p_en, 1'b0);
        check("rr_drop_busy", busy, 1'b1);
        out_req = 1'b1;
        // TO_RX finishes, RX for one cycle, then a full TO_TX before driving again
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("rr_c2p_en%0d", i), c2p_en, i >= 5);
            check($sformatf("rr_busy%0d", i), busy, i != 2 && i != 5);
        end
        p2c = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("loop_in_q%0d", i), in_q, i >= 6);
            check($sformatf("loop_c2p_en%0d", i), c2p_en, 1'b1);
        end
        rst = 1'b1;
        tick();
        check("mid_rst_c2p_en", c2p_en, 1'b0);
        check("mid_rst_drive", drive, 1'b0);
        check("mid_rst_in_q", in_q, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("post_rst_busy%0d", i), busy, i <= 2);
            check($sformatf("post_rst_c2p_en%0d", i), c2p_en, i >= 3);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
